// File: rtl/pipe_ctrl_pkg.sv
// Shared hold codes and interrupt-entry FSM encodings for the pipeline control block.
// Hold codes are ordered so that any code >= HOLD_PC freezes the PC register.
package pipe_ctrl_pkg;

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_IRQ_DRAIN = 2'd1,
    ST_IRQ_JUMP  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_flush_counter.sv
// Down-counter timing the wrong-path flush window; load beats decrement, decrement stops at zero.
// One-cycle update latency; freezes whenever dec_en is low (pipeline held).
module flush_counter #(
  parameter int W = 3
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec_en,
  output logic         o_nonzero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_nonzero = (cnt_q != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Merges execute jumps, stall requests and interrupt entry into PC jump/hold/flush controls.
// Jump and hold are combinational (0 cycles); interrupt entry waits in IRQ_DRAIN while any hold is up.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_ex_jump_flag,
  input  logic [31:0] i_ex_jump_addr,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_hold_req,
  input  logic        i_bus_hold_req,
  input  logic        i_irq,
  input  logic        i_irq_enable,
  input  logic [31:0] i_irq_vector,
  output logic        o_jump_flag,
  output logic [31:0] o_jump_addr,
  output logic [2:0]  o_hold_flag,
  output logic        o_flush,
  output logic        o_irq_ack,
  output logic [31:0] o_epc,
  output logic        o_irq_busy
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        irq_ack;
  logic        irq_take;
  logic [2:0]  hold_code;
  logic        flush_nz;

  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    jump_flag = 1'b0;
    jump_addr = '0;
    irq_ack   = 1'b0;
    irq_take  = 1'b0;
    hold_code = (i_bus_hold_req || i_ex_hold_req || (state_q == ST_IRQ_DRAIN))
              ? HOLD_ID : HOLD_NONE;
    case (state_q)
      ST_RUN: begin
        jump_flag = i_ex_jump_flag;
        jump_addr = i_ex_jump_addr;
        // A coinciding execute jump wins; the level irq is simply retried later.
        irq_take  = i_irq && i_irq_enable && !i_ex_jump_flag
                 && !i_ex_hold_req && !i_bus_hold_req;
        if (irq_take) begin
          state_d = ST_IRQ_DRAIN;
          epc_d   = i_ex_pc;
        end
      end
      ST_IRQ_DRAIN: begin
        if (!i_ex_hold_req && !i_bus_hold_req) begin
          state_d = ST_IRQ_JUMP;
        end
      end
      ST_IRQ_JUMP: begin
        jump_flag = 1'b1;
        jump_addr = i_irq_vector;
        irq_ack   = 1'b1;
        state_d   = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

  flush_counter #(
    .W (FLUSH_CNT_W)
  ) u_flush_counter (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (jump_flag),
    .i_load_val (FLUSH_LOAD),
    .i_dec_en   (hold_code == HOLD_NONE),
    .o_nonzero  (flush_nz)
  );

  // Reset masks the combinational paths too, so downstream stages see a quiet bus.
  assign o_jump_flag = !i_reset && jump_flag;
  assign o_jump_addr = i_reset ? '0 : jump_addr;
  assign o_hold_flag = i_reset ? HOLD_NONE : hold_code;
  assign o_flush     = !i_reset && (jump_flag || flush_nz);
  assign o_irq_ack   = !i_reset && irq_ack;
  assign o_epc       = i_reset ? '0 : epc_q;
  assign o_irq_busy  = !i_reset && (state_q != ST_RUN);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: stimulus pushes hand-computed per-cycle expectations,
// an independent monitor pops and compares them at each falling edge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_jump_flag;
  logic [31:0] ex_jump_addr;
  logic [31:0] ex_pc;
  logic        ex_hold_req;
  logic        bus_hold_req;
  logic        irq;
  logic        irq_enable;
  logic [31:0] irq_vector;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic [2:0]  hold_flag;
  logic        flush;
  logic        irq_ack;
  logic [31:0] epc;
  logic        irq_busy;

  typedef struct packed {
    logic        jf;
    logic [31:0] ja;
    logic [2:0]  hold;
    logic        fl;
    logic        ack;
    logic [31:0] epc;
    logic        busy;
  } obs_t;

  obs_t  exp_q[$];
  string lbl_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(2)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_ex_jump_flag (ex_jump_flag),
    .i_ex_jump_addr (ex_jump_addr),
    .i_ex_pc        (ex_pc),
    .i_ex_hold_req  (ex_hold_req),
    .i_bus_hold_req (bus_hold_req),
    .i_irq          (irq),
    .i_irq_enable   (irq_enable),
    .i_irq_vector   (irq_vector),
    .o_jump_flag    (jump_flag),
    .o_jump_addr    (jump_addr),
    .o_hold_flag    (hold_flag),
    .o_flush        (flush),
    .o_irq_ack      (irq_ack),
    .o_epc          (epc),
    .o_irq_busy     (irq_busy)
  );

  task automatic drv(input logic r, input logic exj, input logic [31:0] exa,
                     input logic [31:0] expc, input logic exh, input logic bus,
                     input logic ir, input logic en);
    rst          = r;
    ex_jump_flag = exj;
    ex_jump_addr = exa;
    ex_pc        = expc;
    ex_hold_req  = exh;
    bus_hold_req = bus;
    irq          = ir;
    irq_enable   = en;
  endtask

  task automatic chk(input string lbl, input logic jf, input logic [31:0] ja,
                     input logic [2:0] hold, input logic fl, input logic ack,
                     input logic [31:0] ep, input logic busy);
    obs_t e;
    e = '{jf: jf, ja: ja, hold: hold, fl: fl, ack: ack, epc: ep, busy: busy};
    exp_q.push_back(e);
    lbl_q.push_back(lbl);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge where an expectation is pending, compare the full output set.
  initial begin
    obs_t  act;
    obs_t  e;
    string l;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        l   = lbl_q.pop_front();
        act = '{jf: jump_flag, ja: jump_addr, hold: hold_flag, fl: flush,
                ack: irq_ack, epc: epc, busy: irq_busy};
        n_chk++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got jf=%0b ja=%h hold=%0d flush=%0b ack=%0b epc=%h busy=%0b; want jf=%0b ja=%h hold=%0d flush=%0b ack=%0b epc=%h busy=%0b",
                   l, act.jf, act.ja, act.hold, act.fl, act.ack, act.epc, act.busy,
                   e.jf, e.ja, e.hold, e.fl, e.ack, e.epc, e.busy);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got %0d checks, want completion", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    irq_vector = 32'h80;
    drv(1, 1, 32'h100, 32'h40, 1, 1, 1, 1);
    @(posedge clk);
    #1;

    // Reset masks even the combinational jump/hold paths.
    drv(1, 1, 32'h100, 32'h40, 1, 1, 1, 1); chk("rst_forced", 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0);            chk("rst_hold",   0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("idle",       0, 0, 0, 0, 0, 0, 0);

    // Execute jump: same-cycle redirect, flush for two cycles.
    drv(0, 1, 32'h100, 0, 0, 0, 0, 0);      chk("jmp",     1, 32'h100, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("jmp_fl1", 0, 0, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("jmp_fl0", 0, 0, 0, 0, 0, 0, 0);

    // Bus hold alone.
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 1, 0, 0);          chk("bus_hold", 0, 0, 3, 0, 0, 0, 0);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("bus_rel",  0, 0, 0, 0, 0, 0, 0);

    // Bus hold during a flush stretches it by three cycles.
    drv(0, 1, 32'h104, 0, 0, 0, 0, 0);      chk("jf_jmp",  1, 32'h104, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 1, 0, 0);          chk("jf_held", 0, 0, 3, 1, 0, 0, 0);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("jf_ext",  0, 0, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("jf_end",  0, 0, 0, 0, 0, 0, 0);

    // Interrupt entry with no holds; an execute jump during drain is ignored.
    drv(0, 0, 0, 32'h40, 0, 0, 1, 1);       chk("irq_take",  0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 32'h40, 0, 0, 1, 1);       chk("irq_drain", 0, 0, 3, 0, 0, 32'h40, 1);
    drv(0, 0, 0, 32'h40, 0, 0, 1, 1);       chk("irq_jump",  1, 32'h80, 0, 1, 1, 32'h40, 1);
    drv(0, 0, 0, 32'h40, 0, 0, 0, 0);       chk("irq_ret",   0, 0, 0, 1, 0, 32'h40, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("irq_fl0",   0, 0, 0, 0, 0, 32'h40, 0);

    // Interrupt coinciding with an execute jump: the jump wins, irq taken next free cycle.
    drv(0, 1, 32'h200, 32'h44, 0, 0, 1, 1); chk("co_jmp",   1, 32'h200, 0, 1, 0, 32'h40, 0);
    drv(0, 0, 0, 32'h48, 0, 0, 1, 1);       chk("co_take",  0, 0, 0, 1, 0, 32'h40, 0);
    drv(0, 0, 0, 32'h48, 0, 0, 1, 1);       chk("co_drain", 0, 0, 3, 0, 0, 32'h48, 1);
    drv(0, 0, 0, 32'h48, 0, 0, 1, 1);       chk("co_jump",  1, 32'h80, 0, 1, 1, 32'h48, 1);
    drv(0, 0, 0, 32'h48, 0, 0, 0, 0);       chk("co_ret",   0, 0, 0, 1, 0, 32'h48, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("co_fl0",   0, 0, 0, 0, 0, 32'h48, 0);

    // Execute hold blocks the take; a bus hold in drain adds one cycle.
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 32'h50, 1, 0, 1, 1);     chk("eh_wait", 0, 0, 3, 0, 0, 32'h48, 0);
    end
    drv(0, 0, 0, 32'h50, 0, 0, 1, 1);       chk("eh_take",   0, 0, 0, 0, 0, 32'h48, 0);
    drv(0, 0, 0, 32'h50, 0, 1, 1, 1);       chk("eh_drain1", 0, 0, 3, 0, 0, 32'h50, 1);
    drv(0, 0, 0, 32'h50, 0, 0, 1, 1);       chk("eh_drain2", 0, 0, 3, 0, 0, 32'h50, 1);
    drv(0, 0, 0, 32'h50, 0, 0, 1, 1);       chk("eh_jump",   1, 32'h80, 0, 1, 1, 32'h50, 1);
    drv(0, 0, 0, 32'h50, 0, 0, 0, 0);       chk("eh_ret",    0, 0, 0, 1, 0, 32'h50, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("eh_fl0",    0, 0, 0, 0, 0, 32'h50, 0);

    // Interrupt disabled: never taken.
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 32'h54, 0, 0, 1, 0);     chk("irq_off", 0, 0, 0, 0, 0, 32'h50, 0);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("off_idle", 0, 0, 0, 0, 0, 32'h50, 0);

    // Reset during drain abandons entry without an ack.
    drv(0, 0, 0, 32'h60, 0, 0, 1, 1);       chk("rd_take",  0, 0, 0, 0, 0, 32'h50, 0);
    drv(0, 0, 0, 32'h60, 0, 0, 1, 1);       chk("rd_drain", 0, 0, 3, 0, 0, 32'h60, 1);
    drv(1, 0, 0, 32'h60, 0, 0, 1, 1);       chk("rd_reset", 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 32'h60, 0, 0, 0, 0);       chk("rd_run",   0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("rd_idle",  0, 0, 0, 0, 0, 0, 0);

    // Jump and hold together: both asserted, counter still reloads.
    drv(0, 1, 32'h300, 0, 0, 1, 0, 0);      chk("jh_both", 1, 32'h300, 3, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("jh_fl1",  0, 0, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("jh_fl0",  0, 0, 0, 0, 0, 0, 0);

    // Back-to-back jumps reload the flush window.
    drv(0, 1, 32'h110, 0, 0, 0, 0, 0);      chk("rl_j1",  1, 32'h110, 0, 1, 0, 0, 0);
    drv(0, 1, 32'h120, 0, 0, 0, 0, 0);      chk("rl_j2",  1, 32'h120, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("rl_fl1", 0, 0, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);            chk("rl_fl0", 0, 0, 0, 0, 0, 0, 0);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control block for the RV32 core. It merges jump requests from the execute stage and interrupt entry into the single jump port of the PC register. It merges stall requests from execute and the memory bus into the 3-bit hold code consumed by the PC register and the IF/ID stages. It also sequences interrupt entry: it drains the pipeline, captures the return PC, and redirects fetch to the trap vector. It also times flush of wrong-path instructions after every redirect.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `o_flush` stays high, counting the redirect cycle; legal range 1–7.
- `i_clock` input 1: single clock; all state updates on its rising edge.
- `i_reset` input 1: synchronous, active-high reset.
- `i_ex_jump_flag` input 1: execute-stage branch/jump/mret taken.
- `i_ex_jump_addr` input 32: execute-stage jump target.
- `i_ex_pc` input 32: PC of the instruction currently in execute.
- `i_ex_hold_req` input 1: execute-stage multi-cycle op busy (divider).
- `i_bus_hold_req` input 1: memory bus wait.
- `i_irq` input 1: level interrupt request, held by the source until acked.
- `i_irq_enable` input 1: global interrupt enable (mstatus.MIE).
- `i_irq_vector` input 32: trap vector address.
- `o_jump_flag` output 1: redirect PC this cycle.
- `o_jump_addr` output 32: redirect target.
- `o_hold_flag` output 3: hold code to PC register and IF/ID.
- `o_flush` output 1: kill IF/ID contents.
- `o_irq_ack` output 1: one-cycle pulse when the vector jump is issued.
- `o_epc` output 32: captured return PC, registered.
- `o_irq_busy` output 1: interrupt entry in progress.

## Operation
- Hold codes:
  - `HOLD_NONE`=0, `HOLD_PC`=1, `HOLD_IF`=2, `HOLD_ID`=3.
  - The PC register freezes when the code is ≥ `HOLD_PC`.
- `o_hold_flag` = `HOLD_ID` if `i_bus_hold_req`, `i_ex_hold_req`, or state is `IRQ_DRAIN`; otherwise `HOLD_NONE`.
- FSM states: `RUN`, `IRQ_DRAIN`, `IRQ_JUMP`.
- `RUN`:
  - `o_jump_flag`/`o_jump_addr` pass through the `i_ex_jump_*` inputs combinationally.
  - Interrupt is taken when `i_irq & i_irq_enable & ~i_ex_jump_flag & ~i_ex_hold_req & ~i_bus_hold_req`.
  - On take: capture `o_epc` ← `i_ex_pc` and go to `IRQ_DRAIN`.
  - If an ex jump coincides with the interrupt, the jump wins; the interrupt stays pending (level) and is retried later.
- `IRQ_DRAIN`:
  - Lasts one cycle at minimum; exits to `IRQ_JUMP` when both hold requests are low.
  - Execute jumps in this state are ignored.
- `IRQ_JUMP`:
  - Outputs: `o_jump_flag`=1, `o_jump_addr`=`i_irq_vector`, `o_irq_ack`=1.
  - Next state is `RUN`.
- `o_irq_busy` = state ≠ `RUN`.
- Flush counter, 3 bits:
  - Any cycle with `o_jump_flag`=1 loads `FLUSH_CYCLES`-1.
  - Otherwise it decrements when nonzero and `o_hold_flag`==`HOLD_NONE`.
  - It freezes while held.
  - `o_flush` = `o_jump_flag` | (counter ≠ 0).
  - A new jump during a flush reloads the counter.
- Reset:
  - While `i_reset`=1, all outputs are forced to 0, including the combinational paths.
  - Next-cycle state: `RUN`, counter 0, `o_epc` 0.
  - Reset during `IRQ_DRAIN`/`IRQ_JUMP` abandons the entry; no ack is issued.

## Timing
- Execute jump to `o_jump_flag`: 0 cycles (combinational). The PC register holds the target after the next edge.
- Hold request to `o_hold_flag`: 0 cycles.
- Interrupt entry with no holds:
  - Take cycle T (still `RUN`, no hold).
  - T+1: `IRQ_DRAIN`, hold=3.
  - T+2: `IRQ_JUMP`, jump+ack.
  - T+3: `RUN`.
- Each extra cycle of bus/ex hold in `IRQ_DRAIN` adds one cycle.
- `o_epc` is valid from T+1 until the next take.
- Jump and hold in the same cycle (`RUN`): both are asserted. The PC register gives jump priority; the counter reloads.

## Structure
- Shared package/defines:
  - `HOLD_NONE`/`HOLD_PC`/`HOLD_IF`/`HOLD_ID`, extending the existing hold defines.
  - FSM state encodings.
- Sub-module `flush_counter`: load, decrement-enable, nonzero flag; parameterised by width.
- The rest is flat.

## Test plan
- Execute jump: `i_ex_jump_flag`=1, addr 0x0000_0100 → same-cycle jump to 0x100; `o_flush` high for 2 cycles with default `FLUSH_CYCLES`.
- Bus hold: `i_bus_hold_req` high for 3 cycles → `o_hold_flag`=3 for exactly those cycles; if asserted during a flush, the flush is extended by 3 cycles.
- Interrupt entry: `i_irq`=1, enable=1, `i_ex_pc`=0x40, vector 0x80 →
  - `o_epc`=0x40 at T+1.
  - Jump to 0x80 with one-cycle `o_irq_ack` at T+2.
  - `o_irq_busy` high for T+1..T+2.
- Interrupt coinciding with an execute jump to 0x200 → jump to 0x200 is taken; interrupt is taken the following free cycle with `o_epc` = new `i_ex_pc`.
- Interrupt with `i_ex_hold_req` high for 4 cycles → no take until hold drops; `i_irq_enable`=0 → never taken.
- `i_reset` asserted in `IRQ_DRAIN` → no ack; all outputs 0; next cycle is `RUN` with `o_epc`=0.
